// File: rtl/midi_voice_alloc_if.sv
// MIDI byte input plus per-voice synth control outputs for midi_voice_alloc.
// The byte source / synth bank drives the master side; the allocator is the slave.
interface midi_voice_alloc_if #(
  parameter int NVOICES = 4
);
  logic [7:0]           rx_byte;
  logic                 rx_byte_valid;
  logic                 panic;
  logic [7*NVOICES-1:0] voice_note;
  logic [7*NVOICES-1:0] voice_vel;
  logic [NVOICES-1:0]   voice_gate;
  logic [NVOICES-1:0]   voice_trig;

  modport master (
    output rx_byte, rx_byte_valid, panic,
    input  voice_note, voice_vel, voice_gate, voice_trig
  );

  modport slave (
    input  rx_byte, rx_byte_valid, panic,
    output voice_note, voice_vel, voice_gate, voice_trig
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// MIDI channel-voice parser with running status, feeding a note allocator that
// retriggers, takes the lowest free voice, or steals the oldest.
module midi_voice_alloc #(
  parameter int NVOICES = 4,
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input logic               clk,
  input logic               rst,
  midi_voice_alloc_if.slave bus
);
  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IW-1:0] OLDEST = IW'(NVOICES - 1);

  typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} parse_state_t;

  parse_state_t state_reg, state_next;
  logic [7:0]   status_reg, status_next;
  logic [6:0]   d1_reg, d1_next;

  logic         msg_done;
  logic [6:0]   msg_d1, msg_d2;
  logic         chan_ok;
  logic         ev_on_next, ev_off_next, ev_alloff_next;
  logic         ev_on_reg, ev_off_reg, ev_alloff_reg;
  logic [6:0]   ev_note_reg, ev_vel_reg;

  assign chan_ok = (OMNI != 0) || (status_reg[3:0] == 4'(CHANNEL));

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    d1_next     = d1_reg;
    msg_done    = 1'b0;
    msg_d1      = d1_reg;
    msg_d2      = bus.rx_byte[6:0];
    if (bus.rx_byte_valid) begin
      if (bus.rx_byte >= 8'hF8) begin
        state_next = state_reg;
      end else if (bus.rx_byte[7]) begin
        if (bus.rx_byte[7:4] == 4'hF) begin
          state_next  = NO_STATUS;
          status_next = 8'h00;
        end else begin
          state_next  = WAIT_D1;
          status_next = bus.rx_byte;
        end
      end else begin
        case (state_reg)
          WAIT_D1: begin
            // Program change and channel pressure carry a single data byte
            if (status_reg[7:5] == 3'b110) begin
              msg_done = 1'b1;
              msg_d1   = bus.rx_byte[6:0];
            end else begin
              d1_next    = bus.rx_byte[6:0];
              state_next = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done   = 1'b1;
            state_next = WAIT_D1;
          end
          default: state_next = state_reg;
        endcase
      end
    end
  end

  always_comb begin
    ev_on_next     = 1'b0;
    ev_off_next    = 1'b0;
    ev_alloff_next = 1'b0;
    if (msg_done && chan_ok) begin
      case (status_reg[7:4])
        4'h9: begin
          ev_on_next  = (msg_d2 != 7'd0);
          ev_off_next = (msg_d2 == 7'd0);
        end
        4'h8: ev_off_next = 1'b1;
        4'hB: ev_alloff_next = (msg_d1 == 7'd120) || (msg_d1 == 7'd123);
        default: ev_on_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= NO_STATUS;
      status_reg    <= 8'h00;
      d1_reg        <= 7'd0;
      ev_on_reg     <= 1'b0;
      ev_off_reg    <= 1'b0;
      ev_alloff_reg <= 1'b0;
      ev_note_reg   <= 7'd0;
      ev_vel_reg    <= 7'd0;
    end else begin
      state_reg     <= state_next;
      status_reg    <= status_next;
      d1_reg        <= d1_next;
      ev_on_reg     <= ev_on_next && !bus.panic;
      ev_off_reg    <= ev_off_next && !bus.panic;
      ev_alloff_reg <= ev_alloff_next && !bus.panic;
      ev_note_reg   <= msg_d1;
      ev_vel_reg    <= msg_d2;
    end
  end

  logic [6:0]    note_all [NVOICES];
  logic          gate_all [NVOICES];
  logic [IW-1:0] age_all  [NVOICES];

  logic          hit, free;
  logic [IW-1:0] hit_idx, free_idx, old_idx, chosen;
  logic [IW-1:0] chosen_age;

  // Descending scans so the lowest matching index wins
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (gate_all[i] && note_all[i] == ev_note_reg) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!gate_all[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
      if (age_all[i] == OLDEST) old_idx = IW'(i);
    end
    if (hit)       chosen = hit_idx;
    else if (free) chosen = free_idx;
    else           chosen = old_idx;
  end

  assign chosen_age = age_all[chosen];

  generate
    for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice
      logic [6:0]    note_reg, vel_reg;
      logic          gate_reg, trig_reg;
      logic [IW-1:0] age_reg;
      logic          pick;

      assign pick = ev_on_reg && (chosen == IW'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          note_reg <= 7'd0;
          vel_reg  <= 7'd0;
          gate_reg <= 1'b0;
          trig_reg <= 1'b0;
          age_reg  <= IW'(gi);
        end else begin
          trig_reg <= 1'b0;
          if (bus.panic) begin
            gate_reg <= 1'b0;
          end else if (pick) begin
            note_reg <= ev_note_reg;
            vel_reg  <= ev_vel_reg;
            gate_reg <= 1'b1;
            trig_reg <= 1'b1;
          end else if (ev_off_reg && gate_reg && note_reg == ev_note_reg) begin
            gate_reg <= 1'b0;
          end else if (ev_alloff_reg) begin
            gate_reg <= 1'b0;
          end
          if (!bus.panic && ev_on_reg) begin
            if (pick)                         age_reg <= '0;
            else if (age_reg < chosen_age)    age_reg <= age_reg + 1'b1;
          end
        end
      end

      assign note_all[gi] = note_reg;
      assign gate_all[gi] = gate_reg;
      assign age_all[gi]  = age_reg;
      assign bus.voice_note[7*gi +: 7] = note_reg;
      assign bus.voice_vel[7*gi +: 7]  = vel_reg;
      assign bus.voice_gate[gi]        = gate_reg;
      assign bus.voice_trig[gi]        = trig_reg;
    end
  endgenerate
endmodule
